// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate self-test sequencer.
// Holds the FSM state enum, vector sizing and standard truth tables.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } gts_state_t;

    localparam int VEC_W   = 2;
    localparam int NUM_VEC = 4;

    // Bit {a,b} of a table is the expected gate output for that vector.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_test_settle_timer.sv
// Settle counter: counts cycles while enabled and flags the final one.
// Ports: clk, rst (async high), load_i (clear), en_i (count), expire_o.
module gate_test_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    // One extra bit keeps the width non-zero when SETTLE_CYCLES is 1.
    localparam int W = $clog2(SETTLE_CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == W'(SETTLE_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for a 2-input gate: sweeps all vectors, checks the
// gate output against a latched truth table and reports a verdict.
// Ports: clk, rst (async high), start, exp_tt[3:0], dut_y in;
//        dut_a, dut_b, busy, done, pass, fail_idx[1:0], err_cnt out.
// Macro GATE_TEST_SEQ_ERRCNT_EN builds the saturating mismatch counter;
// without it err_cnt is tied to 0.
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       exp_tt,
    input  logic             dut_y,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_idx,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PW = $clog2(PASSES + 1);

    gts_state_t       state_q;
    logic [VEC_W-1:0] vec_q;
    logic [PW-1:0]    pcnt_q;
    logic [3:0]       tt_q;
    logic             fail_seen_q;
    logic             ok_q;
    logic             pass_q;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       fidx_q;

    logic accept;
    logic expire;
    logic mism;
    logic last;

    assign accept = (state_q == IDLE) && start;
    assign mism   = dut_y != tt_q[vec_q];
    assign last   = (vec_q == VEC_W'(NUM_VEC - 1))
                 && (pcnt_q == PW'(PASSES - 1));

    gate_test_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .en_i    (state_q == SETTLE),
        .expire_o(expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            pcnt_q      <= '0;
            tt_q        <= '0;
            fail_seen_q <= 1'b0;
            ok_q        <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fidx_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q       <= '0;
                        pcnt_q      <= '0;
                        fail_seen_q <= 1'b0;
                        fidx_q      <= '0;
                        ok_q        <= 1'b1;
                        tt_q        <= exp_tt;
                        busy_q      <= 1'b1;
                        state_q     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (expire) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (mism) begin
                        ok_q <= 1'b0;
                        if (!fail_seen_q) begin
                            fidx_q      <= vec_q;
                            fail_seen_q <= 1'b1;
                        end
                    end
                    if (last) begin
                        // ok_q has not yet absorbed this cycle's compare.
                        pass_q  <= ok_q & ~mism;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        vec_q <= vec_q + 1'b1;
                        if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                            pcnt_q <= pcnt_q + 1'b1;
                        end
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef GATE_TEST_SEQ_ERRCNT_EN
    logic [CNT_W-1:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (accept) begin
            err_q <= '0;
        end else if (state_q == CHECK && mism && err_q != '1) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

    assign dut_a    = vec_q[1];
    assign dut_b    = vec_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_idx = fidx_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: two instances (default and CNT_W=2,
// PASSES=2), each driving an AND gate, with a scoreboard of verdicts.
module tb_gate_test_sequencer;
    import gate_test_pkg::*;

    localparam int S = 2;

    typedef struct {
        logic       pass;
        logic [1:0] fidx;
        logic [7:0] ec;
        int         lat;
    } exp_t;

    logic       clk, rst;
    logic       start, start2;
    logic [3:0] exp_tt, exp_tt2;
    logic       dut_y, dut_y2;
    logic       dut_a, dut_b, busy, done, pass;
    logic       dut_a2, dut_b2, busy2, done2, pass2;
    logic [1:0] fail_idx, fail_idx2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    exp_t sb[$];
    int   n_cmp, n_err, cyc;

    assign dut_y  = dut_a & dut_b;
    assign dut_y2 = dut_a2 & dut_b2;

    gate_test_sequencer #(
        .SETTLE_CYCLES(S), .PASSES(1), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt),
        .dut_y(dut_y), .dut_a(dut_a), .dut_b(dut_b), .busy(busy),
        .done(done), .pass(pass), .fail_idx(fail_idx), .err_cnt(err_cnt)
    );

    gate_test_sequencer #(
        .SETTLE_CYCLES(S), .PASSES(2), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst), .start(start2), .exp_tt(exp_tt2),
        .dut_y(dut_y2), .dut_a(dut_a2), .dut_b(dut_b2), .busy(busy2),
        .done(done2), .pass(pass2), .fail_idx(fail_idx2),
        .err_cnt(err_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [3:0] gtt,
                                   input logic [3:0] ett,
                                   input int passes, input int cntw);
        exp_t e;
        int   n;
        bit   seen;
        n = 0;
        seen = 0;
        e.fidx = 2'b00;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < 4; v++) begin
                if (gtt[v] !== ett[v]) begin
                    if (!seen) begin
                        e.fidx = 2'(v);
                        seen = 1;
                    end
                    n++;
                end
            end
        end
        e.pass = (n == 0);
`ifdef GATE_TEST_SEQ_ERRCNT_EN
        e.ec = 8'((n > (1 << cntw) - 1) ? (1 << cntw) - 1 : n);
`else
        e.ec = 8'd0;
`endif
        e.lat = 4 * passes * (S + 1);
        return e;
    endfunction

    // Waits for done (or done2) and returns cycles since t0; -1 on timeout.
    task automatic wait_done(input bit which, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (which ? done2 : done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({dut_a, dut_b, busy, done, pass} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl got %b want 00000",
                     {dut_a, dut_b, busy, done, pass});
        end
        n_cmp++;
        if ({fail_idx, err_cnt} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_res got %h want 0", {fail_idx, err_cnt});
        end
        n_cmp++;
        if ({dut_a2, dut_b2, busy2, done2, pass2, fail_idx2, err_cnt2}
            !== 9'b0) begin
            n_err++;
            $display("FAIL reset_sat got %b want 0",
                     {dut_a2, dut_b2, busy2, done2, pass2, fail_idx2,
                      err_cnt2});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_and_pass();
        int t0, lat;
        logic [23:0] seq, eseq;
        logic bsy;
        exp_t e;
        sb.push_back(model(TT_AND, TT_AND, 1, 8));
        exp_tt = TT_AND;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        seq = '0;
        eseq = '0;
        bsy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            seq  = {seq[21:0], dut_a, dut_b};
            eseq = {eseq[21:0], 2'(k / 3)};
            bsy  = bsy & busy;
        end
        n_cmp++;
        if (seq !== eseq) begin
            n_err++;
            $display("FAIL and_seq got %h want %h", seq, eseq);
        end
        n_cmp++;
        if (bsy !== 1'b1) begin
            n_err++;
            $display("FAIL and_busy got %b want 1", bsy);
        end
        wait_done(0, t0, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin
            n_err++;
            $display("FAIL and_lat got %0d want %0d", lat, e.lat);
        end
        n_cmp++;
        if ({pass, fail_idx, err_cnt} !== {e.pass, e.fidx, e.ec}) begin
            n_err++;
            $display("FAIL and_res got %b/%b/%0d want %b/%b/%0d",
                     pass, fail_idx, err_cnt, e.pass, e.fidx, e.ec);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL and_pulse got %b want 0", done);
        end
    endtask

    task automatic test_or_mismatch();
        int t0, lat;
        exp_t e;
        sb.push_back(model(TT_AND, TT_OR, 1, 8));
        exp_tt = TT_OR;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        wait_done(0, t0, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin
            n_err++;
            $display("FAIL or_lat got %0d want %0d", lat, e.lat);
        end
        n_cmp++;
        if ({pass, fail_idx, err_cnt} !== {e.pass, e.fidx, e.ec}) begin
            n_err++;
            $display("FAIL or_res got %b/%b/%0d want %b/%b/%0d",
                     pass, fail_idx, err_cnt, e.pass, e.fidx, e.ec);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int nd, lat;
        logic [23:0] seq, eseq;
        exp_t e;
        sb.push_back(model(TT_AND, TT_AND, 1, 8));
        exp_tt = TT_AND;
        start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({pass, fail_idx} !== 3'b000) begin
            n_err++;
            $display("FAIL clr_on_start got %b want 000", {pass, fail_idx});
        end
        nd = 0;
        lat = -1;
        seq = '0;
        eseq = '0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 12) begin
                seq  = {seq[21:0], dut_a, dut_b};
                eseq = {eseq[21:0], 2'(k / 3)};
            end
            if (done) begin
                nd++;
                lat = k;
            end
            start = (k == 3 || k == 7 || k == 12);
        end
        start = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (seq !== eseq) begin
            n_err++;
            $display("FAIL ign_seq got %h want %h", seq, eseq);
        end
        n_cmp++;
        if (nd !== 1) begin
            n_err++;
            $display("FAIL ign_ndone got %0d want 1", nd);
        end
        n_cmp++;
        if (lat !== e.lat) begin
            n_err++;
            $display("FAIL ign_lat got %0d want %0d", lat, e.lat);
        end
        n_cmp++;
        if ({pass, fail_idx, err_cnt} !== {e.pass, e.fidx, e.ec}) begin
            n_err++;
            $display("FAIL ign_res got %b/%b/%0d want %b/%b/%0d",
                     pass, fail_idx, err_cnt, e.pass, e.fidx, e.ec);
        end
    endtask

    task automatic test_reset_midrun();
        int t0, lat, nd;
        exp_t e;
        exp_tt = TT_NAND;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dut_a, dut_b, busy, done, pass, fail_idx, err_cnt} !== 15'b0)
        begin
            n_err++;
            $display("FAIL mid_rst got %b want 0",
                     {dut_a, dut_b, busy, done, pass, fail_idx, err_cnt});
        end
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin
            n_err++;
            $display("FAIL mid_nodone got %0d want 0", nd);
        end
        sb.push_back(model(TT_AND, TT_AND, 1, 8));
        exp_tt = TT_AND;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        n_cmp++;
        if ({dut_a, dut_b, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL mid_restart got %b want 001",
                     {dut_a, dut_b, busy});
        end
        wait_done(0, t0, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin
            n_err++;
            $display("FAIL mid_lat got %0d want %0d", lat, e.lat);
        end
        n_cmp++;
        if ({pass, fail_idx, err_cnt} !== {e.pass, e.fidx, e.ec}) begin
            n_err++;
            $display("FAIL mid_res got %b/%b/%0d want %b/%b/%0d",
                     pass, fail_idx, err_cnt, e.pass, e.fidx, e.ec);
        end
        @(negedge clk);
    endtask

    task automatic test_latch_tt();
        int t0, lat;
        exp_t e;
        // The table in force at the start edge is the one that counts.
        sb.push_back(model(TT_AND, TT_AND, 1, 8));
        exp_tt = TT_AND;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_tt = TT_XOR;
        t0 = cyc;
        wait_done(0, t0, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin
            n_err++;
            $display("FAIL latch_lat got %0d want %0d", lat, e.lat);
        end
        n_cmp++;
        if ({pass, fail_idx, err_cnt} !== {e.pass, e.fidx, e.ec}) begin
            n_err++;
            $display("FAIL latch_res got %b/%b/%0d want %b/%b/%0d",
                     pass, fail_idx, err_cnt, e.pass, e.fidx, e.ec);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t0, nd;
        exp_t e, e2;
        e = model(TT_AND, TT_AND, 1, 8);
        e2 = model(TT_AND, TT_XOR, 1, 8);
        // Second run starts after one DONE cycle and one IDLE cycle.
        e2.lat = 2 * e.lat + 2;
        sb.push_back(e);
        sb.push_back(e2);
        exp_tt = TT_AND;
        start = 1'b1;
        @(negedge clk);
        exp_tt = TT_XOR;
        t0 = cyc;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                e = sb.pop_front();
                n_cmp++;
                if (cyc - t0 !== e.lat) begin
                    n_err++;
                    $display("FAIL b2b_lat%0d got %0d want %0d",
                             nd, cyc - t0, e.lat);
                end
                n_cmp++;
                if ({pass, fail_idx, err_cnt} !== {e.pass, e.fidx, e.ec})
                begin
                    n_err++;
                    $display("FAIL b2b_res%0d got %b/%b/%0d want %b/%b/%0d",
                             nd, pass, fail_idx, err_cnt,
                             e.pass, e.fidx, e.ec);
                end
                nd++;
                if (nd == 2) break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (nd !== 2) begin
            n_err++;
            $display("FAIL b2b_ndone got %0d want 2", nd);
        end
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturate();
        int t0, lat;
        exp_t e;
        sb.push_back(model(TT_AND, TT_NAND, 2, 2));
        exp_tt2 = TT_NAND;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        t0 = cyc;
        wait_done(1, t0, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin
            n_err++;
            $display("FAIL sat_lat got %0d want %0d", lat, e.lat);
        end
        n_cmp++;
        if ({pass2, fail_idx2, err_cnt2} !== {e.pass, e.fidx, e.ec[1:0]})
        begin
            n_err++;
            $display("FAIL sat_res got %b/%b/%0d want %b/%b/%0d",
                     pass2, fail_idx2, err_cnt2, e.pass, e.fidx,
                     e.ec[1:0]);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        start = 1'b0;
        start2 = 1'b0;
        exp_tt = 4'b0;
        exp_tt2 = 4'b0;
        rst = 1'b1;
        test_reset();
        test_and_pass();
        test_or_mismatch();
        test_start_ignored();
        test_reset_midrun();
        test_latch_tt();
        test_back_to_back();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
